gb_camera_capture: RTL and testbench

//  Capture sequencer and CAM register file for the Game Boy Camera mapper. Sits beside the camera mapper on the A000-BFFF window,

---
 rtl/gb_camera_capture.sv | 174 +++++++++++++++++
 tb/tb_gb_camera_capture.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gb_camera_capture.sv
// Game Boy Camera capture sequencer and CAM register file (A000-BFFF window).
// Latency: accepted pixel byte -> cap_wr one clk later when cram is free; exposure E*EXP_TICKS ce_cpu ticks.
// Backpressure: img_ready drops while the single holding register is full; the CPU always wins cram.
// Optional feature macro: GB_CAM_TESTPAT_EN (A000 bit3 selects a generated test pattern).
module gb_camera_capture #(
  parameter int          EXP_TICKS = 64,
  parameter int          IMG_BYTES = 3584,
  parameter logic [12:0] IMG_BASE  = 13'h0100
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        enable,
  input  logic        ce_cpu,
  input  logic        cam_sel,
  input  logic        cart_wr,
  input  logic [6:0]  cart_addr,
  input  logic [7:0]  cart_di,
  output logic [7:0]  cam_do,
  input  logic        cpu_cram_busy,
  input  logic        img_valid,
  input  logic [7:0]  img_data,
  output logic        img_ready,
  output logic        cap_wr,
  output logic [16:0] cap_addr,
  output logic [7:0]  cap_data,
  output logic        cap_busy
);

  typedef enum logic [1:0] {S_IDLE, S_EXPOSE, S_READOUT, S_DONE} state_t;

  localparam logic [11:0] LAST_IDX = 12'(IMG_BYTES - 1);

  state_t      state;
  logic [7:0]  regs [1:53];
  logic [2:1]  ctl;
  logic        tp_bit;
  logic        tp_run;
  logic [31:0] exp_cnt;
  logic [31:0] exp_target;
  logic [11:0] idx;
  logic        hold_vld;
  logic [7:0]  hold_dat;

  logic reg_wr, ctl_wr, start_req, abort_req;

  assign reg_wr    = cam_sel & cart_wr & ce_cpu;
  assign ctl_wr    = reg_wr && (cart_addr == 7'd0);
  assign start_req = ctl_wr && cart_di[0] && (state == S_IDLE);
  assign abort_req = ctl_wr && !cart_di[0] && (state != S_IDLE);

  // stream is only accepted while reading out from the camera with an empty holding register
  assign img_ready = enable && (state == S_READOUT) && !hold_vld && !tp_run;

`ifndef GB_CAM_TESTPAT_EN
  assign tp_bit = 1'b0;
  assign tp_run = 1'b0;
`endif

  // CAM register file 0x01-0x35; the mapper deselect clears it like a reset
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      for (int i = 1; i <= 53; i++) regs[i] <= 8'h00;
    end else if (!enable) begin
      for (int i = 1; i <= 53; i++) regs[i] <= 8'h00;
    end else if (reg_wr && (cart_addr >= 7'd1) && (cart_addr <= 7'd53)) begin
      regs[cart_addr[5:0]] <= cart_di;
    end
  end

  // combinational register readback; unmapped indices read zero
  always_comb begin
    cam_do = 8'h00;
    if (cart_addr == 7'd0)
      cam_do = {4'b0000, tp_bit, ctl, cap_busy};
    else if (cart_addr <= 7'd53)
      cam_do = regs[cart_addr[5:0]];
  end

  // capture sequencer: control bits, exposure timer, holding register and cram write port
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      ctl        <= 2'b00;
      exp_cnt    <= 32'd0;
      exp_target <= 32'd0;
      idx        <= 12'd0;
      hold_vld   <= 1'b0;
      hold_dat   <= 8'h00;
      cap_wr     <= 1'b0;
      cap_addr   <= 17'd0;
      cap_data   <= 8'h00;
      cap_busy   <= 1'b0;
`ifdef GB_CAM_TESTPAT_EN
      tp_bit     <= 1'b0;
      tp_run     <= 1'b0;
`endif
    end else if (!enable) begin
      state      <= S_IDLE;
      ctl        <= 2'b00;
      exp_cnt    <= 32'd0;
      exp_target <= 32'd0;
      idx        <= 12'd0;
      hold_vld   <= 1'b0;
      hold_dat   <= 8'h00;
      cap_wr     <= 1'b0;
      cap_addr   <= 17'd0;
      cap_data   <= 8'h00;
      cap_busy   <= 1'b0;
`ifdef GB_CAM_TESTPAT_EN
      tp_bit     <= 1'b0;
      tp_run     <= 1'b0;
`endif
    end else begin
      cap_wr <= 1'b0;
      if (ctl_wr) begin
        ctl <= cart_di[2:1];
`ifdef GB_CAM_TESTPAT_EN
        tp_bit <= cart_di[3];
`endif
      end
      if (abort_req) begin
        // abort drops any pending byte; nothing more reaches cram
        state    <= S_IDLE;
        cap_busy <= 1'b0;
        hold_vld <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (start_req) begin
              state      <= S_EXPOSE;
              cap_busy   <= 1'b1;
              exp_cnt    <= 32'd0;
              exp_target <= 32'({regs[2], regs[3]}) * 32'(EXP_TICKS);
              idx        <= 12'd0;
              hold_vld   <= 1'b0;
`ifdef GB_CAM_TESTPAT_EN
              tp_run     <= cart_di[3];
`endif
            end
          end
          S_EXPOSE: begin
            if (exp_cnt >= exp_target)
              state <= S_READOUT;
            else if (ce_cpu)
              exp_cnt <= exp_cnt + 32'd1;
          end
          S_READOUT: begin
            if (tp_run || hold_vld) begin
              // write only when the CPU leaves cram alone; otherwise keep the byte
              if (!cpu_cram_busy) begin
                cap_wr   <= 1'b1;
                cap_addr <= {4'd0, IMG_BASE + {1'b0, idx}};
                cap_data <= tp_run ? (idx[7:0] ^ idx[11:4]) : hold_dat;
                hold_vld <= 1'b0;
                if (idx == LAST_IDX)
                  state <= S_DONE;
                else
                  idx <= idx + 12'd1;
              end
            end else if (img_valid) begin
              hold_vld <= 1'b1;
              hold_dat <= img_data;
            end
          end
          default: begin
            state    <= S_IDLE;
            cap_busy <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gb_camera_capture.sv
// Directed bench for gb_camera_capture: register file, exposure timing, streaming,
// cram contention, abort, restart-while-busy, async reset and enable clear.
// GB_CAM_TESTPAT_EN enables the test-pattern scenario and bit3 readback expectations.
module tb_gb_camera_capture;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b1;
  logic        ce_cpu = 1'b1;
  logic        cam_sel = 1'b0;
  logic        cart_wr = 1'b0;
  logic [6:0]  cart_addr = 7'd0;
  logic [7:0]  cart_di = 8'h00;
  logic [7:0]  cam_do;
  logic        cpu_cram_busy = 1'b0;
  logic        img_valid = 1'b0;
  logic [7:0]  img_data = 8'h00;
  logic        img_ready;
  logic        cap_wr;
  logic [16:0] cap_addr;
  logic [7:0]  cap_data;
  logic        cap_busy;

  int vectors = 0;
  int miscompares = 0;

  // cram write monitor state
  int       wr_cnt = 0;
  int       bad_cnt = 0;
  int       viol_cnt = 0;
  logic     tp_mode = 1'b0;
  logic     busy_prev = 1'b0;
  logic [7:0] byte_112 = 8'h00;

  gb_camera_capture dut (
    .clk_sys(clk_sys), .reset(reset), .enable(enable), .ce_cpu(ce_cpu),
    .cam_sel(cam_sel), .cart_wr(cart_wr), .cart_addr(cart_addr), .cart_di(cart_di),
    .cam_do(cam_do), .cpu_cram_busy(cpu_cram_busy), .img_valid(img_valid),
    .img_data(img_data), .img_ready(img_ready), .cap_wr(cap_wr), .cap_addr(cap_addr),
    .cap_data(cap_data), .cap_busy(cap_busy)
  );

  always #5 clk_sys = ~clk_sys;

  // sample the write port mid-cycle; each write must land at the next frame offset
  always @(negedge clk_sys) begin
    logic [11:0] mi;
    logic [7:0]  ed;
    logic [16:0] ea;
    if (cap_wr) begin
      mi = wr_cnt[11:0];
      ed = tp_mode ? (mi[7:0] ^ mi[11:4]) : mi[7:0];
      ea = {4'd0, 13'h0100 + {1'b0, mi}};
      if (cap_addr !== ea || cap_data !== ed) bad_cnt++;
      if (cap_addr == 17'h00112) byte_112 = cap_data;
      if (busy_prev) viol_cnt++;
      wr_cnt++;
    end
    busy_prev = cpu_cram_busy;
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic clear_mon(input logic tp);
    wr_cnt = 0; bad_cnt = 0; viol_cnt = 0; tp_mode = tp; byte_112 = 8'h00;
  endtask

  task automatic cpu_write(input logic [6:0] a, input logic [7:0] d);
    cam_sel = 1'b1; cart_wr = 1'b1; cart_addr = a; cart_di = d;
    tick();
    cam_sel = 1'b0; cart_wr = 1'b0;
  endtask

  task automatic cpu_read(input logic [6:0] a, output logic [7:0] d);
    cart_addr = a;
    #1;
    d = cam_do;
  endtask

  // present bytes first..first+n-1 (data = index); busy_at raises cpu_cram_busy for 5 clk
  task automatic stream(input int first, input int n, input int busy_at);
    int   busy_left;
    logic was_rdy;
    logic taken;
    busy_left = 0;
    for (int i = first; i < first + n; i++) begin
      img_valid = 1'b1;
      img_data = i[7:0];
      taken = 1'b0;
      for (int c = 0; c < 64 && !taken; c++) begin
        if (i == busy_at && c == 0) busy_left = 5;
        cpu_cram_busy = (busy_left > 0);
        if (busy_left > 0) busy_left--;
        was_rdy = img_ready;
        tick();
        if (was_rdy) taken = 1'b1;
      end
      if (!taken) begin
        vectors++; miscompares++;
        $display("FAIL stream_timeout: byte %0d not accepted within 64 clk", i);
        img_valid = 1'b0; cpu_cram_busy = 1'b0;
        return;
      end
    end
    img_valid = 1'b0;
    cpu_cram_busy = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] d;
    #2;
    vectors++; if (cap_busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", cap_busy); end
    vectors++; if (cap_wr !== 1'b0) begin miscompares++; $display("FAIL reset_wr: got %b want 0", cap_wr); end
    vectors++; if (img_ready !== 1'b0) begin miscompares++; $display("FAIL reset_rdy: got %b want 0", img_ready); end
    vectors++; if (cap_addr !== 17'd0 || cap_data !== 8'h00) begin miscompares++; $display("FAIL reset_port: got %h/%h want 0/0", cap_addr, cap_data); end
    cpu_read(7'h00, d);
    vectors++; if (d !== 8'h00) begin miscompares++; $display("FAIL reset_a000: got %h want 00", d); end
    @(negedge clk_sys);
    reset = 1'b0;
    tick();
  endtask

  task automatic test_regs();
    logic [7:0] d;
    logic [7:0] exp8;
    cpu_write(7'h10, 8'h5A);
    cpu_write(7'h35, 8'hFF);
    cpu_write(7'h01, 8'h33);
    cpu_write(7'h36, 8'h77);
    cpu_write(7'h00, 8'h06);
    ce_cpu = 1'b0;
    cpu_write(7'h10, 8'h11);
    ce_cpu = 1'b1;
    cpu_read(7'h10, d);
    vectors++; if (d !== 8'h5A) begin miscompares++; $display("FAIL reg_10: got %h want 5a", d); end
    cpu_read(7'h35, d);
    vectors++; if (d !== 8'hFF) begin miscompares++; $display("FAIL reg_35: got %h want ff", d); end
    cpu_read(7'h01, d);
    vectors++; if (d !== 8'h33) begin miscompares++; $display("FAIL reg_01: got %h want 33", d); end
    cpu_read(7'h36, d);
    vectors++; if (d !== 8'h00) begin miscompares++; $display("FAIL reg_36: got %h want 00", d); end
    cpu_read(7'h7F, d);
    vectors++; if (d !== 8'h00) begin miscompares++; $display("FAIL reg_7f: got %h want 00", d); end
    cpu_read(7'h00, d);
    vectors++; if (d !== 8'h06) begin miscompares++; $display("FAIL reg_ctl: got %h want 06", d); end
    vectors++; if (cap_busy !== 1'b0) begin miscompares++; $display("FAIL ctl_nostart: got %b want 0", cap_busy); end
    tick();
    cpu_write(7'h00, 8'h08);
`ifdef GB_CAM_TESTPAT_EN
    exp8 = 8'h08;
`else
    exp8 = 8'h00;
`endif
    cpu_read(7'h00, d);
    vectors++; if (d !== exp8) begin miscompares++; $display("FAIL ctl_bit3: got %h want %h", d, exp8); end
    tick();
    cpu_write(7'h00, 8'h00);
  endtask

  task automatic test_expose_frame();
    logic [7:0] d;
    cpu_write(7'h02, 8'h00);
    cpu_write(7'h03, 8'h01);
    clear_mon(1'b0);
    cpu_write(7'h00, 8'h01);
    vectors++; if (cap_busy !== 1'b1) begin miscompares++; $display("FAIL exp_busy: got %b want 1", cap_busy); end
    cpu_write(7'h03, 8'h05);
    repeat (63) tick();
    vectors++; if (img_ready !== 1'b0 || cap_busy !== 1'b1) begin miscompares++; $display("FAIL exp_tick63: got rdy=%b busy=%b want 0/1", img_ready, cap_busy); end
    tick();
    vectors++; if (img_ready !== 1'b1) begin miscompares++; $display("FAIL exp_tick64: got rdy=%b want 1", img_ready); end
    stream(0, 3584, -1);
    vectors++; if (cap_busy !== 1'b1) begin miscompares++; $display("FAIL frame_busy_last: got %b want 1", cap_busy); end
    repeat (2) tick();
    vectors++; if (cap_busy !== 1'b0) begin miscompares++; $display("FAIL frame_busy_clr: got %b want 0", cap_busy); end
    tick();
    vectors++; if (wr_cnt !== 3584) begin miscompares++; $display("FAIL frame_count: got %0d want 3584", wr_cnt); end
    vectors++; if (bad_cnt !== 0) begin miscompares++; $display("FAIL frame_addr_data: got %0d bad writes want 0", bad_cnt); end
    cpu_read(7'h00, d);
    vectors++; if (d !== 8'h00) begin miscompares++; $display("FAIL frame_a000: got %h want 00", d); end
  endtask

  task automatic test_cram_contention();
    cpu_write(7'h03, 8'h00);
    clear_mon(1'b0);
    cpu_write(7'h00, 8'h01);
    stream(0, 20, 11);
    repeat (2) tick();
    vectors++; if (wr_cnt !== 20) begin miscompares++; $display("FAIL cont_count: got %0d want 20", wr_cnt); end
    vectors++; if (bad_cnt !== 0) begin miscompares++; $display("FAIL cont_addr_data: got %0d bad writes want 0", bad_cnt); end
    vectors++; if (viol_cnt !== 0) begin miscompares++; $display("FAIL cont_cpu_wins: got %0d writes during busy want 0", viol_cnt); end
    cpu_write(7'h00, 8'h00);
    vectors++; if (cap_busy !== 1'b0) begin miscompares++; $display("FAIL cont_abort: got %b want 0", cap_busy); end
  endtask

  task automatic test_abort();
    logic [7:0] d;
    clear_mon(1'b0);
    cpu_write(7'h00, 8'h01);
    stream(0, 100, -1);
    tick();
    cpu_write(7'h00, 8'h00);
    vectors++; if (cap_busy !== 1'b0 || img_ready !== 1'b0) begin miscompares++; $display("FAIL abort_next_clk: got busy=%b rdy=%b want 0/0", cap_busy, img_ready); end
    img_valid = 1'b1;
    repeat (20) tick();
    vectors++; if (wr_cnt !== 100) begin miscompares++; $display("FAIL abort_count: got %0d want 100", wr_cnt); end
    vectors++; if (bad_cnt !== 0) begin miscompares++; $display("FAIL abort_addr_data: got %0d bad writes want 0", bad_cnt); end
    vectors++; if (img_ready !== 1'b0) begin miscompares++; $display("FAIL abort_rdy: got %b want 0", img_ready); end
    img_valid = 1'b0;
    cpu_read(7'h00, d);
    vectors++; if (d !== 8'h00) begin miscompares++; $display("FAIL abort_a000: got %h want 00", d); end
  endtask

  task automatic test_restart_ignored();
    clear_mon(1'b0);
    cpu_write(7'h00, 8'h01);
    stream(0, 50, -1);
    cpu_write(7'h00, 8'h01);
    vectors++; if (cap_busy !== 1'b1) begin miscompares++; $display("FAIL restart_busy: got %b want 1", cap_busy); end
    stream(50, 3534, -1);
    repeat (3) tick();
    vectors++; if (wr_cnt !== 3584) begin miscompares++; $display("FAIL restart_count: got %0d want 3584", wr_cnt); end
    vectors++; if (bad_cnt !== 0) begin miscompares++; $display("FAIL restart_addr_data: got %0d bad writes want 0", bad_cnt); end
    vectors++; if (cap_busy !== 1'b0) begin miscompares++; $display("FAIL restart_done: got %b want 0", cap_busy); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    int nz;
    cpu_write(7'h10, 8'h77);
    cpu_write(7'h02, 8'h10);
    cpu_write(7'h00, 8'h01);
    repeat (10) tick();
    vectors++; if (cap_busy !== 1'b1 || img_ready !== 1'b0) begin miscompares++; $display("FAIL mid_expose: got busy=%b rdy=%b want 1/0", cap_busy, img_ready); end
    reset = 1'b1;
    #1;
    vectors++; if (cap_busy !== 1'b0) begin miscompares++; $display("FAIL mid_reset_busy: got %b want 0", cap_busy); end
    nz = 0;
    for (int a = 0; a < 128; a++) begin
      cpu_read(a[6:0], d);
      if (d !== 8'h00) nz++;
    end
    vectors++; if (nz !== 0) begin miscompares++; $display("FAIL mid_reset_regs: got %0d nonzero regs want 0", nz); end
    cpu_read(7'h36, d);
    vectors++; if (d !== 8'h00) begin miscompares++; $display("FAIL mid_reset_a036: got %h want 00", d); end
    @(negedge clk_sys);
    reset = 1'b0;
    tick();
  endtask

  task automatic test_enable_clear();
    logic [7:0] d;
    cpu_write(7'h10, 8'h42);
    cpu_read(7'h10, d);
    vectors++; if (d !== 8'h42) begin miscompares++; $display("FAIL en_pre: got %h want 42", d); end
    enable = 1'b0;
    tick();
    enable = 1'b1;
    cpu_read(7'h10, d);
    vectors++; if (d !== 8'h00) begin miscompares++; $display("FAIL en_clear: got %h want 00", d); end
    tick();
  endtask

`ifdef GB_CAM_TESTPAT_EN
  task automatic test_testpat();
    int waited;
    cpu_write(7'h02, 8'h00);
    cpu_write(7'h03, 8'h00);
    clear_mon(1'b1);
    img_valid = 1'b1;
    cpu_write(7'h00, 8'h09);
    repeat (20) tick();
    vectors++; if (img_ready !== 1'b0) begin miscompares++; $display("FAIL tp_rdy: got %b want 0", img_ready); end
    waited = 0;
    while (cap_busy === 1'b1 && waited < 5000) begin tick(); waited++; end
    img_valid = 1'b0;
    vectors++; if (cap_busy !== 1'b0) begin miscompares++; $display("FAIL tp_timeout: busy still %b after 5000 clk", cap_busy); end
    tick();
    vectors++; if (wr_cnt !== 3584) begin miscompares++; $display("FAIL tp_count: got %0d want 3584", wr_cnt); end
    vectors++; if (bad_cnt !== 0) begin miscompares++; $display("FAIL tp_pattern: got %0d bad writes want 0", bad_cnt); end
    vectors++; if (byte_112 !== 8'h13) begin miscompares++; $display("FAIL tp_0112: got %h want 13", byte_112); end
  endtask
`endif

  initial begin
    test_reset();
    test_regs();
    test_expose_frame();
    test_cram_contention();
    test_abort();
    test_restart_ignored();
    test_reset_mid();
    test_enable_clear();
`ifdef GB_CAM_TESTPAT_EN
    test_testpat();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
